// File: rtl/btn_scan_pkg.sv
// Shared types and constants for the time-multiplexed button scanner.
package btn_scan_pkg;

    typedef enum logic {
        EVT_RELEASE = 1'b0,
        EVT_PRESS   = 1'b1
    } evt_kind_e;

    localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/button_scan_arbiter_if.sv
// Event channel (valid/ready plus coalesce-drop strobe) from the scanner to its consumer.
interface button_scan_arbiter_if #(
    parameter int unsigned ID_W = 2
) ();
    import btn_scan_pkg::*;

    logic            valid;
    logic [ID_W-1:0] id;
    evt_kind_e       kind;
    logic            ready;
    logic            drop;

    modport master (output valid, id, kind, drop, input ready);
    modport slave  (input valid, id, kind, drop, output ready);

endinterface

// File: rtl/button_scan_arbiter_rr_arbiter.sv
// Round-robin arbiter: search starts one above the last advanced grant.
module rr_arbiter #(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [IDX_W-1:0] grant_c,
    output logic             grant_valid_c
);

    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] idx;

    // First requester found walking upward from last_q+1, wrapping at N.
    always_comb begin
        grant_c       = '0;
        grant_valid_c = 1'b0;
        idx           = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = IDX_W'((32'(last_q) + i) % N);
            if (!grant_valid_c && req[idx]) begin
                grant_c       = idx;
                grant_valid_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= '0;
        end else if (advance && grant_valid_c) begin
            last_q <= grant_c;
        end
    end

endmodule

// File: rtl/button_scan_arbiter.sv
// Shared-slot button debouncer with round-robin event presentation.
// Optional: define BTN_SCAN_RELEASE_EVT_EN to also queue release events.
module button_scan_arbiter
    import btn_scan_pkg::*;
#(
    parameter int unsigned NUM_BTN        = 4,
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned STABLE_SAMPLES = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NUM_BTN-1:0]    i_btn,
    output logic [NUM_BTN-1:0]    o_debounced,
    output logic [NUM_BTN-1:0]    o_pulse,
    button_scan_arbiter_if.master evt
);

    localparam int unsigned ID_W  = $clog2(NUM_BTN);
    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W = $clog2(STABLE_SAMPLES + 1);
`ifdef BTN_SCAN_RELEASE_EVT_EN
    localparam int unsigned REQ_N = 2 * NUM_BTN;
`else
    localparam int unsigned REQ_N = NUM_BTN;
`endif
    localparam int unsigned REQ_W = $clog2(REQ_N);

    logic [SYNC_STAGES-1:0][NUM_BTN-1:0] sync_q;
    logic [NUM_BTN-1:0]                  btn_s;
    logic [DIV_W-1:0]                    div_q;
    logic                                tick_c;
    logic [ID_W-1:0]                     slot_q;
    logic [NUM_BTN-1:0][CNT_W-1:0]       cnt_q;
    logic [NUM_BTN-1:0][CNT_W-1:0]       cnt_d;
    logic [NUM_BTN-1:0]                  flip_c;
    logic [NUM_BTN-1:0]                  rise_c;
    logic [NUM_BTN-1:0]                  press_pend_q;
    logic [NUM_BTN-1:0]                  press_clr_c;
    logic [REQ_N-1:0]                    req_c;
    logic [REQ_N-1:0]                    arb_req_c;
    logic [REQ_N-1:0]                    cur_onehot_c;
    logic [REQ_N-1:0]                    clr_req_c;
    logic [REQ_W-1:0]                    cur_q;
    logic [REQ_W-1:0]                    grant_c;
    logic                                grant_valid_c;
    logic                                xfer_c;
    logic                                drop_c;

    assign btn_s  = sync_q[SYNC_STAGES-1];
    assign tick_c = (div_q == DIV_W'(SCAN_DIV - 1));

    // Service the button in the current slot; at most one flip per clock.
    always_comb begin
        cnt_d  = cnt_q;
        flip_c = '0;
        if (tick_c) begin
            if (btn_s[slot_q] == o_debounced[slot_q]) begin
                cnt_d[slot_q] = '0;
            end else if (cnt_q[slot_q] < CNT_W'(STABLE_SAMPLES - 1)) begin
                cnt_d[slot_q] = cnt_q[slot_q] + CNT_W'(1);
            end else begin
                cnt_d[slot_q]  = '0;
                flip_c[slot_q] = 1'b1;
            end
        end
    end

    assign rise_c = flip_c & ~o_debounced;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q      <= '0;
            div_q       <= '0;
            slot_q      <= '0;
            cnt_q       <= '0;
            o_debounced <= '0;
            o_pulse     <= '0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], i_btn};
            div_q       <= tick_c ? '0 : div_q + DIV_W'(1);
            if (tick_c) begin
                slot_q <= (slot_q == ID_W'(NUM_BTN - 1)) ? '0 : slot_q + ID_W'(1);
            end
            cnt_q       <= cnt_d;
            o_debounced <= o_debounced ^ flip_c;
            o_pulse     <= rise_c;
        end
    end

    // While an event is presented the arbiter sees only that request, so the
    // pointer lands on exactly the id that was accepted.
    assign xfer_c       = evt.valid && evt.ready;
    assign cur_onehot_c = REQ_N'(1) << cur_q;
    assign clr_req_c    = xfer_c ? cur_onehot_c : '0;
    assign arb_req_c    = evt.valid ? cur_onehot_c : req_c;

`ifdef BTN_SCAN_RELEASE_EVT_EN
    logic [NUM_BTN-1:0] fall_c;
    logic [NUM_BTN-1:0] rel_pend_q;
    logic [NUM_BTN-1:0] rel_clr_c;

    assign fall_c = flip_c & o_debounced;

    // Press and release of one button sit side by side, press first.
    for (genvar k = 0; k < NUM_BTN; k++) begin : g_req
        assign req_c[2*k]     = press_pend_q[k];
        assign req_c[2*k+1]   = rel_pend_q[k];
        assign press_clr_c[k] = clr_req_c[2*k];
        assign rel_clr_c[k]   = clr_req_c[2*k+1];
    end

    assign drop_c = (|(rise_c & press_pend_q & ~press_clr_c))
                 || (|(fall_c & rel_pend_q & ~rel_clr_c));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rel_pend_q <= '0;
        end else begin
            rel_pend_q <= (rel_pend_q & ~rel_clr_c) | fall_c;
        end
    end
`else
    assign req_c       = press_pend_q;
    assign press_clr_c = clr_req_c;
    assign drop_c      = |(rise_c & press_pend_q & ~press_clr_c);
    assign evt.kind    = EVT_PRESS;
`endif

    // Set wins over a same-cycle clear, keeping the bit pending without a drop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            press_pend_q <= '0;
        end else begin
            press_pend_q <= (press_pend_q & ~press_clr_c) | rise_c;
        end
    end

    rr_arbiter #(
        .N (REQ_N)
    ) u_arb (
        .clk           (i_clk),
        .rst           (i_rst),
        .req           (arb_req_c),
        .advance       (xfer_c),
        .grant_c       (grant_c),
        .grant_valid_c (grant_valid_c)
    );

    // Presentation register: one idle cycle after every transfer.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            evt.valid <= 1'b0;
            evt.id    <= '0;
            evt.drop  <= 1'b0;
            cur_q     <= '0;
`ifdef BTN_SCAN_RELEASE_EVT_EN
            evt.kind  <= EVT_RELEASE;
`endif
        end else begin
            evt.drop <= drop_c;
            if (xfer_c) begin
                evt.valid <= 1'b0;
            end else if (!evt.valid && grant_valid_c) begin
                evt.valid <= 1'b1;
                cur_q     <= grant_c;
`ifdef BTN_SCAN_RELEASE_EVT_EN
                evt.id    <= grant_c[REQ_W-1:1];
                evt.kind  <= grant_c[0] ? EVT_RELEASE : EVT_PRESS;
`else
                evt.id    <= grant_c;
`endif
            end
        end
    end

endmodule
